// File: rtl/fact_cu_if.sv
// Control/flag bundle between the factorial control unit and its datapath.
// The slave side is the control unit; the master side is the datapath/requester.
interface fact_cu_if;
   logic go;
   logic gt_in;
   logic gt_fact;
   logic load_cnt;
   logic en;
   logic sel_1;
   logic load_reg;
   logic sel_2;
   logic done;
   logic err;
   logic busy;

   modport master (
      output go, gt_in, gt_fact,
      input  load_cnt, en, sel_1, load_reg, sel_2, done, err, busy
   );

   modport slave (
      input  go, gt_in, gt_fact,
      output load_cnt, en, sel_1, load_reg, sel_2, done, err, busy
   );
endinterface

// File: rtl/fact_cu.sv
// Moore control unit sequencing an iterative n! datapath (down-counter times product).
// All outputs decode from the state register alone.
module fact_cu (
   input  logic       clk,
   input  logic       rst,
   fact_cu_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      CHECK,
      MULT,
      DONE,
      ERR
   } state_t;

   state_t r_state;
   state_t w_next;

   logic w_load_cnt;
   logic w_en;
   logic w_sel_1;
   logic w_load_reg;
   logic w_sel_2;
   logic w_done;
   logic w_err;
   logic w_busy;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // go is only looked at in IDLE, DONE and ERR, so it is ignored while busy
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.go) w_next = bus.gt_in ? ERR : INIT;
         INIT:    w_next = CHECK;
         CHECK:   w_next = bus.gt_fact ? MULT : DONE;
         MULT:    w_next = CHECK;
         DONE:    if (!bus.go) w_next = IDLE;
         ERR:     if (!bus.go) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_load_cnt = 1'b0;
      w_en       = 1'b0;
      w_sel_1    = 1'b0;
      w_load_reg = 1'b0;
      w_sel_2    = 1'b0;
      w_done     = 1'b0;
      w_err      = 1'b0;
      w_busy     = 1'b0;
      case (r_state)
         INIT: begin
            w_load_cnt = 1'b1;
            w_sel_1    = 1'b1;
            w_load_reg = 1'b1;
            w_busy     = 1'b1;
         end
         CHECK: w_busy = 1'b1;
         MULT: begin
            w_en       = 1'b1;
            w_load_reg = 1'b1;
            w_busy     = 1'b1;
         end
         DONE: w_done = 1'b1;
         ERR: begin
            w_err   = 1'b1;
            w_sel_2 = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.load_cnt = w_load_cnt;
   assign bus.en       = w_en;
   assign bus.sel_1    = w_sel_1;
   assign bus.load_reg = w_load_reg;
   assign bus.sel_2    = w_sel_2;
   assign bus.done     = w_done;
   assign bus.err      = w_err;
   assign bus.busy     = w_busy;

endmodule

// File: tb/tb_fact_cu.sv
// Bench for fact_cu: a small behavioural datapath closes the loop, results are
// checked against n! and the expected edge latency computed directly from n.
module tb_fact_cu;

   logic clk;
   logic rst;
   logic [3:0]  r_n;
   logic [3:0]  r_cnt;
   logic [31:0] r_prod;
   logic [31:0] w_nf;
   logic [7:0]  w_outs;

   int unsigned checks = 0;
   int unsigned errors = 0;

   localparam logic [7:0] P_IDLE  = 8'b0000_0000;
   localparam logic [7:0] P_INIT  = 8'b1011_0001;
   localparam logic [7:0] P_CHECK = 8'b0000_0001;
   localparam logic [7:0] P_MULT  = 8'b0101_0001;
   localparam logic [7:0] P_DONE  = 8'b0000_0100;
   localparam logic [7:0] P_ERR   = 8'b0000_1010;

   fact_cu_if bus_if ();

   fact_cu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // datapath: n > 12 check, down-counter, product register, result mux
   assign bus_if.gt_in   = (r_n > 4'd12);
   assign bus_if.gt_fact = (r_cnt > 4'd1);
   assign w_nf   = bus_if.sel_2 ? 32'd0 : r_prod;
   assign w_outs = {bus_if.load_cnt, bus_if.en, bus_if.sel_1, bus_if.load_reg,
                    bus_if.sel_2, bus_if.done, bus_if.err, bus_if.busy};

   always @(posedge clk) begin
      if (bus_if.load_cnt)  r_cnt <= r_n;
      else if (bus_if.en)   r_cnt <= r_cnt - 4'd1;
      if (bus_if.load_reg)  r_prod <= bus_if.sel_1 ? 32'd1 : r_prod * {28'd0, r_cnt};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("load_cnt_en_mutex", {31'd0, bus_if.load_cnt & bus_if.en}, 32'd0);
      chk("done_err_mutex",    {31'd0, bus_if.done & bus_if.err},    32'd0);
   end

   function automatic logic [31:0] fact_ref(input int unsigned n);
      logic [31:0] p = 32'd1;
      for (int unsigned i = 2; i <= n; i++) p = p * i;
      return p;
   endfunction

   function automatic int unsigned lat_ref(input int unsigned n);
      if (n > 12) return 1;
      if (n < 2)  return 3;
      return 2 * n + 1;
   endfunction

   // go raised before edge 1; edges counted until done/err appears
   task automatic run_txn(input logic [3:0] n, input int unsigned exp_lat, input bit exp_err,
                          input logic [31:0] exp_nf, input bit rnd_go);
      int unsigned edges = 0;
      bit fin = 1'b0;
      r_n = n;
      bus_if.go = 1'b1;
      while (!fin && edges < 40) begin
         @(negedge clk);
         edges++;
         if (bus_if.done || bus_if.err) fin = 1'b1;
         else begin
            chk("busy_mid", {31'd0, bus_if.busy}, 32'd1);
            if (rnd_go) bus_if.go = 1'($urandom_range(0, 1));
         end
      end
      chk("finished",  {31'd0, fin}, 32'd1);
      chk("latency",   edges, exp_lat);
      chk("err_flag",  {31'd0, bus_if.err}, {31'd0, exp_err});
      chk("done_flag", {31'd0, bus_if.done}, {31'd0, !exp_err});
      chk("busy_end",  {31'd0, bus_if.busy}, 32'd0);
      chk("nf",        w_nf, exp_nf);
      bus_if.go = 1'b0;
      @(negedge clk);
      chk("idle_after", {24'd0, w_outs}, {24'd0, P_IDLE});
   endtask

   typedef struct {
      logic [3:0]  n;
      int unsigned lat;
      bit          is_err;
      logic [31:0] nf;
   } vec_t;

   vec_t vecs [8];
   logic [7:0] path3 [8];

   initial begin
      vecs[0] = '{n: 4'd0,  lat: 3,  is_err: 1'b0, nf: 32'd1};
      vecs[1] = '{n: 4'd1,  lat: 3,  is_err: 1'b0, nf: 32'd1};
      vecs[2] = '{n: 4'd2,  lat: 5,  is_err: 1'b0, nf: 32'd2};
      vecs[3] = '{n: 4'd3,  lat: 7,  is_err: 1'b0, nf: 32'd6};
      vecs[4] = '{n: 4'd5,  lat: 11, is_err: 1'b0, nf: 32'd120};
      vecs[5] = '{n: 4'd12, lat: 25, is_err: 1'b0, nf: 32'd479001600};
      vecs[6] = '{n: 4'd13, lat: 1,  is_err: 1'b1, nf: 32'd0};
      vecs[7] = '{n: 4'd15, lat: 1,  is_err: 1'b1, nf: 32'd0};
      path3 = '{P_IDLE, P_INIT, P_CHECK, P_MULT, P_CHECK, P_MULT, P_CHECK, P_DONE};

      rst = 1'b1;
      bus_if.go = 1'b0;
      r_n = 4'd0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {24'd0, w_outs}, {24'd0, P_IDLE});
      rst = 1'b0;
      @(negedge clk);

      // n=3: full state path, observed through the output decode of each state
      r_n = 4'd3;
      chk("path3_0", {24'd0, w_outs}, {24'd0, path3[0]});
      bus_if.go = 1'b1;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("path3_%0d", i), {24'd0, w_outs}, {24'd0, path3[i]});
      end
      chk("path3_nf", w_nf, 32'd6);
      bus_if.go = 1'b0;
      @(negedge clk);
      chk("path3_idle", {24'd0, w_outs}, {24'd0, P_IDLE});

      // n=13: rejected on the first edge, released next edge
      r_n = 4'd13;
      bus_if.go = 1'b1;
      @(negedge clk);
      chk("err_outs", {24'd0, w_outs}, {24'd0, P_ERR});
      chk("err_nf", w_nf, 32'd0);
      bus_if.go = 1'b0;
      @(negedge clk);
      chk("err_idle", {24'd0, w_outs}, {24'd0, P_IDLE});

      for (int i = 0; i < 8; i++)
         run_txn(vecs[i].n, vecs[i].lat, vecs[i].is_err, vecs[i].nf, 1'b0);

      // go held through DONE must neither drop done nor retrigger
      r_n = 4'd2;
      bus_if.go = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_done_entry", {24'd0, w_outs}, {24'd0, P_DONE});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_done", {24'd0, w_outs}, {24'd0, P_DONE});
      end
      bus_if.go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_release_idle", {24'd0, w_outs}, {24'd0, P_IDLE});
      end

      // reset on the edge that would enter the second MULT of n=5
      r_n = 4'd5;
      bus_if.go = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mid_mult1", {24'd0, w_outs}, {24'd0, P_MULT});
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outs", {24'd0, w_outs}, {24'd0, P_IDLE});
      rst = 1'b0;
      run_txn(4'd2, 5, 1'b0, 32'd2, 1'b0);

      // go already high when reset releases starts at once
      rst = 1'b1;
      r_n = 4'd4;
      bus_if.go = 1'b1;
      @(negedge clk);
      chk("rst_go_held_idle", {24'd0, w_outs}, {24'd0, P_IDLE});
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_init", {24'd0, w_outs}, {24'd0, P_INIT});
      bus_if.go = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("rst_release_done", {24'd0, w_outs}, {24'd0, P_DONE});
      chk("rst_release_nf", w_nf, 32'd24);
      @(negedge clk);
      chk("rst_release_idle", {24'd0, w_outs}, {24'd0, P_IDLE});

      // random n with go toggled while busy
      for (int i = 0; i < 30; i++) begin
         automatic logic [3:0] rn = 4'($urandom_range(0, 15));
         run_txn(rn, lat_ref(rn), (rn > 4'd12), (rn > 4'd12) ? 32'd0 : fact_ref(rn), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fact_cu.md
FACT_CU -- requirements
Module: fact_cu

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 go  input  1  start request; level-sampled.
REQ-005 gt_in  input  1  datapath flag: requested n > 12 (input out of range).
REQ-006 gt_fact  input  1  datapath flag: current down-count value > 1.
REQ-007 load_cnt  output  1  load datapath down-counter with n.
REQ-008 en  output  1  decrement datapath down-counter.
REQ-009 sel_1  output  1  product-register mux: 1 selects constant 1, 0 selects product*count.
REQ-010 load_reg  output  1  enable write of product register.
REQ-011 sel_2  output  1  result mux: 1 forces nf to 0, 0 passes product.
REQ-012 done  output  1  computation complete; nf valid.
REQ-013 err  output  1  input rejected (n > 12).
REQ-014 busy  output  1  computation in progress (INIT, CHECK, MULT).

Function
REQ-015 fact_cu SHALL be a Moore FSM; every output SHALL decode from the state register only, with no combinational path from go/gt_in/gt_fact to any output.
REQ-016 States SHALL be IDLE, INIT, CHECK, MULT, DONE, ERR.
REQ-017 IDLE: all outputs 0; go=1 & gt_in=1 -> ERR; go=1 & gt_in=0 -> INIT; go=0 -> IDLE.
REQ-018 INIT: load_cnt=1, sel_1=1, load_reg=1, busy=1; unconditionally -> CHECK.
REQ-019 CHECK: busy=1, all datapath controls 0; gt_fact=1 -> MULT, else -> DONE.
REQ-020 MULT: en=1, load_reg=1, sel_1=0, busy=1; unconditionally -> CHECK.
REQ-021 DONE: done=1, sel_2=0, other controls 0; stays while go=1; go=0 -> IDLE.
REQ-022 ERR: err=1, sel_2=1, other controls 0; stays while go=1; go=0 -> IDLE.
REQ-023 load_cnt and en SHALL never be 1 in the same cycle; done and err SHALL never be 1 in the same cycle.
REQ-024 go changes while busy=1 SHALL be ignored; no restart until IDLE is re-entered.
REQ-025 A held go SHALL NOT retrigger: a new computation requires go=0 for at least one cycle (leaving DONE/ERR) then go=1 in IDLE.
REQ-026 Latency: for accepted n = k with k >= 2, done SHALL assert on the 2k+1th rising edge after the edge sampling go=1; for k = 0 or 1, on the 3rd edge.
REQ-027 Latency: rejected n (gt_in=1) SHALL assert err on the 1st edge after go is sampled.
REQ-028 Product register SHALL hold its value in IDLE, DONE and ERR (load_reg=0), so the last result remains readable after done drops.
REQ-029 Arithmetic width and wrap of the product are owned by the datapath; fact_cu SHALL not inspect product values.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE from any state, including mid-MULT, taking priority over go.
REQ-031 After reset all outputs SHALL be 0 (IDLE decode); datapath register contents are unspecified and not cleared by fact_cu.
REQ-032 Reset de-assertion with go=1 SHALL start a computation on the first edge with rst=0.

Verification
REQ-033 rst, then go=1 with n=3 -> state path IDLE,INIT,CHECK,MULT,CHECK,MULT,CHECK,DONE; done=1 on edge 7; nf=6.
REQ-034 go=1 with n=0 and with n=1 -> done=1 on edge 3; nf=1; en never asserted.
REQ-035 go=1 with n=13 -> err=1, sel_2=1 on edge 1; nf=0; load_reg/load_cnt never asserted; go=0 -> IDLE next edge.
REQ-036 go held high through DONE for 5 cycles, then go=0 -> done stays 1 for all 5 cycles, IDLE after release; no second INIT.
REQ-037 rst=1 during second MULT of n=5 -> IDLE on that edge, all outputs 0; subsequent go with n=2 -> done on edge 5, nf=2.
REQ-038 Every cycle of all tests: assert load_cnt&en==0, done&err==0, busy==1 exactly in INIT/CHECK/MULT.
